// File: rtl/fanin_merge_if.sv
// fanin_merge_if
//   Bundles the source-side and consumer-side stream signals of the fan-in
//   merge into one interface.
//   master : the environment (sources + consumer) driving the merge.
//   slave  : the merge block itself.
// Signals:
//   in_en, cfg_sel    per-track enable and config select (track participates
//                     only when both are set)
//   in_valid, in_data per-track valid and payload (track i at i*DATA_W)
//   in_ready          one-hot-or-zero grant back to the sources
//   out_valid/out_data/out_src  buffer head, out_ready consumer accept
interface fanin_merge_if #(
    parameter int NUM_IN = 9,
    parameter int DATA_W = 17,
    parameter int IDX_W  = $clog2(NUM_IN)
);
    logic [NUM_IN-1:0]        in_en;
    logic [NUM_IN-1:0]        cfg_sel;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_src;
    logic                     out_ready;

    modport master (
        output in_en, cfg_sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_en, cfg_sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/fanin_merge.sv
// fanin_merge
//   Registered many-to-one stream merge. Up to NUM_IN participating source
//   tracks are arbitrated round-robin into a 2-entry FIFO of {data, src}
//   whose head drives the single consumer.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fanin_merge_if.slave (sources in, grants out, buffer head out)
module fanin_merge #(
    parameter int NUM_IN = 9,
    parameter int DATA_W = 17,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic          clk,
    input  logic          reset,
    fanin_merge_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_IN - 1);
    localparam logic [IDX_W:0]   NUM_IN_EXT = (IDX_W + 1)'(NUM_IN);

    logic [NUM_IN-1:0] part;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] grant;
    logic [DATA_W-1:0] in_data_arr [NUM_IN];

    logic [DATA_W-1:0] mem_data_reg [2];
    logic [IDX_W-1:0]  mem_src_reg  [2];
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [IDX_W-1:0]  rr_reg;
    logic [IDX_W-1:0]  rr_next;

    logic              space;
    logic              found;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W:0]    scan_sum;
    logic [IDX_W-1:0]  scan_idx;

    // Split the flat payload bus into one word per track.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign in_data_arr[gi] = bus.in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign part  = bus.in_en & bus.cfg_sel;
    assign req   = part & bus.in_valid;
    // Only the registered occupancy gates grants, so out_ready never
    // combinationally reaches in_ready.
    assign space = (count_reg < 2'd2);

    // Round-robin scan: offsets 0..NUM_IN-1 from rr, wrapping modulo NUM_IN.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_sum = {1'b0, rr_reg} + (IDX_W + 1)'(k);
            if (scan_sum >= NUM_IN_EXT) begin
                scan_sum = scan_sum - NUM_IN_EXT;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!found && req[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        // No grant may be issued while reset is asserted.
        if (found && space && !reset) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign push       = |grant;
    assign pop        = bus.out_valid & bus.out_ready;
    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
    assign rr_next    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < 2; e++) begin
                mem_data_reg[e] <= '0;
                mem_src_reg[e]  <= '0;
            end
            count_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            rr_reg     <= '0;
        end else begin
            if (push) begin
                mem_data_reg[wr_ptr_reg] <= in_data_arr[grant_idx];
                mem_src_reg[wr_ptr_reg]  <= grant_idx;
                wr_ptr_reg               <= ~wr_ptr_reg;
                rr_reg                   <= rr_next;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = (count_reg != 2'd0);
    assign bus.out_data  = mem_data_reg[rd_ptr_reg];
    assign bus.out_src   = mem_src_reg[rd_ptr_reg];
endmodule

// File: tb/tb_fanin_merge.sv
module tb_fanin_merge;
    localparam int NUM_IN = 9;
    localparam int DATA_W = 17;
    localparam int IDX_W  = $clog2(NUM_IN);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  src;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fanin_merge_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fanin_merge #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered beats plus next-priority track.
    beat_t             q[$];
    int                rr_m = 0;
    logic [DATA_W-1:0] src_data [NUM_IN];
    bit                rand_data = 1'b0;
    int                dut_grants = 0;
    int                dut_pops = 0;
    logic [NUM_IN-1:0] ready_acc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting participating track scanning from rr_m, or -1.
    function automatic int pick();
        int t;
        if (reset || q.size() >= 2) return -1;
        for (int k = 0; k < NUM_IN; k++) begin
            t = (rr_m + k) % NUM_IN;
            if (bus.in_en[t] && bus.cfg_sel[t] && bus.in_valid[t]) return t;
        end
        return -1;
    endfunction

    task automatic tick();
        int                g;
        logic [NUM_IN-1:0] exp_rdy;
        beat_t             b;
        for (int i = 0; i < NUM_IN; i++) bus.in_data[i*DATA_W +: DATA_W] = src_data[i];
        @(negedge clk);
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].data));
            chk("out_src", 32'(bus.out_src), 32'(q[0].src));
        end
        if (|bus.in_ready) dut_grants++;
        if (bus.out_valid && bus.out_ready) dut_pops++;
        ready_acc = ready_acc | bus.in_ready;
        @(posedge clk);
        if (reset) begin
            q.delete();
            rr_m = 0;
        end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (g >= 0) begin
                b.data = src_data[g];
                b.src  = IDX_W'(g);
                q.push_back(b);
                rr_m = (g + 1) % NUM_IN;
                src_data[g] = rand_data ? DATA_W'($urandom) : src_data[g] + 1'b1;
            end
        end
        #1;
        $display("cycle t=%0t rst=%0b part=%03h valid=%03h ready=%03h exp=%03h q=%0d",
                 $time, reset, bus.in_en & bus.cfg_sel, bus.in_valid, bus.in_ready, exp_rdy, q.size());
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_en     = '0;
        bus.cfg_sel   = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) src_data[i] = DATA_W'($urandom);
        @(posedge clk);
        #1;

        // Reset with random valids: no grants, no output.
        bus.in_en   = '1;
        bus.cfg_sel = '1;
        repeat (2) begin
            bus.in_valid = NUM_IN'($urandom);
            tick();
        end
        reset       = 1'b0;
        bus.in_en   = '0;
        bus.cfg_sel = NUM_IN'($urandom);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_src", 32'(bus.out_src), 32'd0);
        repeat (10) begin
            bus.in_valid = NUM_IN'($urandom);
            tick();
        end

        // Single source streaming 1..16 from track 0.
        bus.in_en     = 9'h001;
        bus.cfg_sel   = 9'h001;
        bus.in_valid  = 9'h001;
        bus.out_ready = 1'b1;
        src_data[0]   = 17'h00001;
        dut_pops      = 0;
        repeat (19) begin
            if (src_data[0] > 17'h00010) bus.in_valid[0] = 1'b0;
            tick();
        end
        chk("single_beats", 32'(dut_pops), 32'd16);

        // Round-robin across all tracks, then drop track 3.
        bus.in_en    = '1;
        bus.cfg_sel  = '1;
        bus.in_valid = '1;
        repeat (20) tick();
        bus.in_valid[3] = 1'b0;
        repeat (12) tick();
        bus.in_valid[3] = 1'b1;

        // Masking: only tracks 5 and 7 participate.
        bus.cfg_sel = 9'h0A0;
        ready_acc   = '0;
        repeat (8) tick();
        chk("mask_leak", 32'(ready_acc & ~9'h0A0), 32'd0);
        chk("mask_both", 32'(ready_acc), 32'h0A0);

        // Drain, then backpressure with tracks 1 and 2.
        bus.in_valid = '0;
        repeat (2) tick();
        bus.cfg_sel   = '1;
        bus.in_valid  = 9'h006;
        bus.out_ready = 1'b0;
        dut_grants    = 0;
        repeat (5) tick();
        chk("bp_grants", 32'(dut_grants), 32'd2);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        bus.in_valid = '0;
        repeat (3) tick();

        // Reset mid-operation with the buffer full.
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 9'h150;
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_grant", 32'(bus.in_ready), 32'h010);
        repeat (4) tick();

        // Randomized traffic, config changes and occasional resets.
        rand_data = 1'b1;
        for (int i = 0; i < NUM_IN; i++) src_data[i] = DATA_W'($urandom);
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.in_en   = NUM_IN'($urandom) | NUM_IN'($urandom);
                bus.cfg_sel = NUM_IN'($urandom) | NUM_IN'($urandom);
            end
            bus.in_valid  = NUM_IN'($urandom) | NUM_IN'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            reset         = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
